rr_mux8_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-to-1 bit-select datapath among 8 requesters.
- Each requester presents a request bit and a data bit. The block grants one requester at a time and drives the mux select.
- Granted data is forwarded on a single output with a valid flag.
- Sits in front of the 8:1 mux datapath, which it instantiates, as its sequencer.

---
 rtl/rr_mux8_pkg.sv | 31 +++
 rtl/mux8_datapath.sv | 15 +
 rtl/rr_mux8_arbiter.sv | 117 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux8_pkg.sv
// Shared types and helpers for the round-robin 8:1 mux arbiter.
package rr_mux8_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotating priority pick: scan req starting at ptr, wrapping at NREQ;
  // the first set bit wins. Returns ptr when nothing is requested.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux8_datapath.sv
// Pure combinational 8:1 bit select.
module mux8_datapath
  import rr_mux8_pkg::*;
(
  input  logic [NREQ-1:0]  din,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  // Select the data bit of the addressed requester.
  always_comb begin
    y = din[sel];
  end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sequencing a shared 8:1 bit-select datapath.
// A holder keeps the grant until it drops its request or has held it
// MAX_HOLD cycles; re-arbitration happens without an idle bubble.
module rr_mux8_arbiter
  import rr_mux8_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             valid,
  output logic             dout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              valid_reg, valid_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [SEL_W-1:0]  ptr_reg, ptr_next;

  logic [SEL_W-1:0]  winner;
  logic [NREQ-1:0]   winner_onehot;
  logic              release_grant;
  logic              mux_y;

  assign winner = rr_pick(req, ptr_reg);

  // One-hot decode of the winning index.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign winner_onehot[gi] = (winner == SEL_W'(gi));
    end
  endgenerate

  // Holder gives up the grant when it stops requesting or hits its hold limit.
  assign release_grant = !req[sel_reg] || (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      gnt_reg      <= '0;
      valid_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= valid_next;
      hold_cnt_reg <= hold_cnt_next;
      ptr_reg      <= ptr_next;
    end
  end

  // Next-state logic: arbitrate from IDLE, hold, hand over or go idle.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    gnt_next      = gnt_reg;
    valid_next    = valid_reg;
    hold_cnt_next = hold_cnt_reg;
    ptr_next      = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          sel_next      = winner;
          gnt_next      = winner_onehot;
          valid_next    = 1'b1;
          hold_cnt_next = '0;
          ptr_next      = winner + SEL_W'(1);
        end
      end
      GRANT: begin
        if (!release_grant) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end else if (|req) begin
          // ptr already points past the holder, so it ranks last here.
          sel_next      = winner;
          gnt_next      = winner_onehot;
          valid_next    = 1'b1;
          hold_cnt_next = '0;
          ptr_next      = winner + SEL_W'(1);
        end else begin
          state_next    = IDLE;
          gnt_next      = '0;
          valid_next    = 1'b0;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mux8_datapath u_mux (
    .din (din),
    .sel (sel_reg),
    .y   (mux_y)
  );

  assign sel   = sel_reg;
  assign gnt   = gnt_reg;
  assign valid = valid_reg;
  assign dout  = valid_reg & mux_y;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed self-checking bench for rr_mux8_arbiter (MAX_HOLD = 4).
module tb_rr_mux8_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       dout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int idx, input logic [7:0] din_v);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(8'h01 << idx));
    check_eq({tag, "_sel"}, 32'(sel), 32'(idx));
    check_eq({tag, "_vld"}, 32'(valid), 32'd1);
    check_eq({tag, "_dout"}, 32'(dout), 32'(din_v[idx]));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_vld"}, 32'(valid), 32'd0);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  // Reset with the supplied request pattern present at release.
  task automatic do_reset(input logic [7:0] req_v);
    rst_n = 1'b0;
    req   = req_v;
    tick();
    rst_n = 1'b1;
  endtask

  // Structural invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      check_eq("inv_valid", 32'(valid), 32'(|gnt));
      if (valid) check_eq("inv_gntsel", 32'(gnt[sel]), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    din   = 8'h00;

    // Reset held with all requests asserted, then idle release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst_hold");
    end
    req   = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("idle");
    end

    // Single requester 2; din = 82 = 0101_0010 so din[2]=0, din[1]=1.
    din = 8'd82;
    req = 8'h04;
    tick();
    check_grant("single2", 2, din);
    check_eq("single2_dout0", 32'(dout), 32'd0);
    req = 8'h02;
    tick();
    check_grant("single1", 1, din);
    check_eq("single1_dout1", 32'(dout), 32'd1);

    // Round robin over all eight, 4 cycles each, no bubbles.
    din = 8'hA5;
    do_reset(8'hFF);
    for (int k = 0; k < 40; k++) begin
      tick();
      check_grant($sformatf("rr%0d", k), (k / 4) % 8, din);
    end

    // Wrap: 7 granted first, then 0 wins over 7 at the hand-over.
    din = 8'h3C;
    do_reset(8'h80);
    tick();
    check_grant("wrap7", 7, din);
    req = 8'h81;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_grant("wrap7_hold", 7, din);
    end
    tick();
    check_grant("wrap0", 0, din);

    // Sole requester 7 is regranted continuously.
    req = 8'h80;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_grant("solo7", 7, din);
    end

    // Early release by 3; 4 then gets a full 4-cycle hold, then 5.
    din = 8'h5A;
    do_reset(8'h08);
    tick();
    check_grant("early3a", 3, din);
    req = 8'h38;
    tick();
    check_grant("early3b", 3, din);
    req = 8'h30;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_grant("early4", 4, din);
    end
    tick();
    check_grant("early5", 5, din);

    // Asynchronous reset between edges during the grant to 5.
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    req = 8'h21;
    #1;
    rst_n = 1'b1;
    #0.5;
    check_idle("async_rel");
    tick();
    check_grant("after_rst0", 0, din);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
